multi_sprite_control: RTL and testbench

MULTI_SPRITE_CONTROL -- requirements
Module: multi_sprite_control

---
 rtl/multi_sprite_control.sv | 190 +++++++++++++++++++
 tb/tb_multi_sprite_control.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_sprite_control.sv
// Multi-channel sprite mover. On each vsync rising edge seen while idle, the block walks
// through NUM_CH channels. For each channel it reads the position byte, writes back the
// position minus one, and writes a colour byte and a character byte at that new screen
// position. Every channel keeps its own colour count and letter count.
//
// Ports:
//   clk      - single clock, all logic on posedge
//   reset    - synchronous, active-high reset
//   vsync    - frame sync level; a sequence starts on its rising edge
//   din      - memory read data, valid one cycle after the read address
//   addr     - registered memory address
//   data     - registered memory write data
//   rw       - registered 1 = write, 0 = read
//   busy     - high in every state except idle
//   done     - one-cycle pulse in the final state of a sequence
//   overrun  - one-cycle pulse when vsync rises while a sequence is running
module multi_sprite_control #(
  parameter int unsigned       NUM_CH       = 2,
  parameter int unsigned       ADDR_W       = 16,
  parameter int unsigned       DATA_W       = 8,
  parameter logic [ADDR_W-1:0] POS_BASE     = 16'h0000,
  parameter logic [ADDR_W-1:0] SCREEN_BASE  = 16'hF000,
  parameter logic [ADDR_W-1:0] COLOR_OFFSET = 16'h0200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic [DATA_W-1:0] din,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              rw,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    StIdle, StRd, StCap, StWpos, StWcol, StWchr, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ChW-1:0]    ch_q, ch_d;
  logic              vsync_q, vsync_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rw_q, rw_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] pos_q, pos_d;
  logic [3:0]        color_q  [NUM_CH];
  logic [3:0]        color_d  [NUM_CH];
  logic [DATA_W-1:0] letter_q [NUM_CH];
  logic [DATA_W-1:0] letter_d [NUM_CH];

  logic              rise;
  logic [DATA_W-1:0] newpos;
  logic [ChW-1:0]    ch_nxt;
  logic [3:0]        cur_color;
  logic [DATA_W-1:0] cur_letter;

  always_comb begin
    rise    = vsync & ~vsync_q;
    // Position written in WPOS; pos_q holds the byte captured in CAP.
    newpos  = pos_q - DATA_W'(1);
    ch_nxt  = ch_q + ChW'(1);

    // Per-channel counters are selected by comparison to keep the index width-clean.
    cur_color  = '0;
    cur_letter = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == ChW'(i)) begin
        cur_color  = color_q[i];
        cur_letter = letter_q[i];
      end
    end

    state_d   = state_q;
    ch_d      = ch_q;
    vsync_d   = vsync;
    addr_d    = addr_q;
    data_d    = data_q;
    rw_d      = 1'b0;
    pos_d     = pos_q;
    color_d   = color_q;
    letter_d  = letter_q;

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StRd;
          ch_d    = '0;
          addr_d  = POS_BASE;
        end
      end
      StRd: begin
        state_d = StCap;
      end
      StCap: begin
        // din answers the read presented in RD; capture it and issue the write-back now.
        pos_d   = din;
        state_d = StWpos;
        addr_d  = POS_BASE + ADDR_W'(ch_q);
        data_d  = din - DATA_W'(1);
        rw_d    = 1'b1;
      end
      StWpos: begin
        state_d = StWcol;
        addr_d  = SCREEN_BASE + COLOR_OFFSET + ADDR_W'(newpos);
        data_d  = DATA_W'(cur_color);
        rw_d    = 1'b1;
      end
      StWcol: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_q == ChW'(i)) color_d[i] = cur_color + 4'd1;
        end
        state_d = StWchr;
        addr_d  = SCREEN_BASE + ADDR_W'(newpos);
        data_d  = cur_letter;
        rw_d    = 1'b1;
      end
      StWchr: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_q == ChW'(i)) letter_d[i] = cur_letter + DATA_W'(1);
        end
        if (ch_q == ChW'(NUM_CH - 1)) begin
          state_d = StDone;
        end else begin
          state_d = StRd;
          ch_d    = ch_nxt;
          addr_d  = POS_BASE + ADDR_W'(ch_nxt);
        end
      end
      StDone: begin
        state_d = StIdle;
        ch_d    = '0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StDone);
    // A rise outside idle is reported only; it never starts or queues a sequence.
    overrun_d = rise & (state_q != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      vsync_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rw_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      pos_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        color_q[i]  <= '0;
        letter_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      vsync_q   <= vsync_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rw_q      <= rw_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      pos_q     <= pos_d;
      color_q   <= color_d;
      letter_q  <= letter_d;
    end
  end

  assign addr    = addr_q;
  assign data    = data_q;
  assign rw      = rw_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_multi_sprite_control.sv
module tb_multi_sprite_control;

  localparam int NCH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vsync = 1'b0;
  logic [7:0]  din = 8'h00;

  logic [15:0] addr, addr1;
  logic [7:0]  data, data1;
  logic        rw, busy, done, overrun;
  logic        rw1, busy1, done1, overrun1;

  always #5 clk = ~clk;

  multi_sprite_control #(.NUM_CH(2)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .din(din),
    .addr(addr), .data(data), .rw(rw), .busy(busy), .done(done), .overrun(overrun)
  );

  multi_sprite_control #(.NUM_CH(1)) dut1 (
    .clk(clk), .reset(reset), .vsync(vsync), .din(din),
    .addr(addr1), .data(data1), .rw(rw1), .busy(busy1), .done(done1), .overrun(overrun1)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (expected bus trace per frame) ----------------
  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        rw;
    logic        dn;
  } ent_t;
  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  ent_t        q[$];
  wr_t         wlog[$];
  logic [3:0]  m_col[NCH];
  logic [7:0]  m_let[NCH];
  logic        m_vq = 1'b0;
  logic [15:0] exp_addr = '0;
  logic [7:0]  exp_data = '0;
  logic        exp_rw = 1'b0, exp_busy = 1'b0, exp_done = 1'b0, exp_ovr = 1'b0;
  int          done_cnt = 0, ovr_cnt = 0, busy_cnt = 0;

  // Whole frame as a list of bus cycles: RD, CAP, WPOS, WCOL, WCHR per channel, then DONE.
  task automatic build(input logic [7:0] d);
    logic [15:0] la;
    logic [7:0]  ld, np;
    ld = exp_data;
    la = exp_addr;
    np = d - 8'd1;
    for (int c = 0; c < NCH; c++) begin
      la = 16'(c);
      q.push_back('{la, ld, 1'b0, 1'b0});
      q.push_back('{la, ld, 1'b0, 1'b0});
      q.push_back('{la, np, 1'b1, 1'b0});
      q.push_back('{16'hF200 + {8'h00, np}, {4'h0, m_col[c]}, 1'b1, 1'b0});
      m_col[c] = m_col[c] + 4'd1;
      la = 16'hF000 + {8'h00, np};
      ld = m_let[c];
      q.push_back('{la, ld, 1'b1, 1'b0});
      m_let[c] = m_let[c] + 8'd1;
    end
    q.push_back('{la, ld, 1'b0, 1'b1});
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      m_col[i] = '0;
      m_let[i] = '0;
    end
  end

  // Compare the DUT against the model, then advance the model with the inputs that the
  // next posedge will sample.
  always @(negedge clk) begin
    ent_t e;
    logic rise;
    chk("addr", addr, exp_addr);
    chk("data", data, exp_data);
    chk("rw", rw, exp_rw);
    chk("busy", busy, exp_busy);
    chk("done", done, exp_done);
    chk("overrun", overrun, exp_ovr);
    if (rw) wlog.push_back('{addr, data});
    if (done) done_cnt++;
    if (overrun) ovr_cnt++;
    if (busy) busy_cnt++;

    if (reset) begin
      exp_addr = '0; exp_data = '0; exp_rw = 0; exp_busy = 0; exp_done = 0; exp_ovr = 0;
      q.delete();
      m_vq = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_col[i] = '0;
        m_let[i] = '0;
      end
    end else begin
      rise = vsync && !m_vq;
      m_vq = vsync;
      exp_ovr = rise && exp_busy;
      if (q.size() == 0 && !exp_busy && rise) build(din);
      if (q.size() > 0) begin
        e = q.pop_front();
        exp_addr = e.a; exp_data = e.d; exp_rw = e.rw; exp_done = e.dn; exp_busy = 1'b1;
      end else begin
        exp_rw = 1'b0; exp_done = 1'b0; exp_busy = 1'b0;
      end
    end
  end

  // Single-channel build: every complete sequence is 6 busy cycles, done on the last, 3 writes.
  int len1 = 0, done_at1 = 0, wr1 = 0, runs1 = 0;
  always @(negedge clk) begin
    if (reset) begin
      len1 = 0; done_at1 = 0; wr1 = 0;
    end else if (busy1) begin
      len1++;
      if (done1) done_at1 = len1;
      if (rw1) wr1++;
    end else if (len1 > 0) begin
      chk("nch1_busy_len", len1, 6);
      chk("nch1_done_pos", done_at1, 6);
      chk("nch1_writes", wr1, 3);
      runs1++;
      len1 = 0; done_at1 = 0; wr1 = 0;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic frame(input logic [7:0] d);
    int d0, b0;
    d0 = done_cnt;
    b0 = busy_cnt;
    wlog.delete();
    din = d;
    vsync = 1'b1;
    cyc(1);
    vsync = 1'b0;
    cyc(14);
    chk("frame_done_pulses", done_cnt - d0, 1);
    chk("frame_busy_cycles", busy_cnt - b0, 11);
  endtask

  // Both channels carry the same colour/letter count in these frames.
  task automatic check_frame(input logic [7:0] d, input logic [3:0] c, input logic [7:0] l);
    logic [15:0] ea[6];
    logic [7:0]  ed[6];
    logic [7:0]  np;
    int          n;
    np = d - 8'd1;
    for (int k = 0; k < 2; k++) begin
      ea[3*k]   = 16'(k);                 ed[3*k]   = np;
      ea[3*k+1] = 16'hF200 + {8'h00, np}; ed[3*k+1] = {4'h0, c};
      ea[3*k+2] = 16'hF000 + {8'h00, np}; ed[3*k+2] = l;
    end
    chk("write_count", wlog.size(), 6);
    n = (wlog.size() < 6) ? wlog.size() : 6;
    for (int i = 0; i < n; i++) begin
      chk("write_addr", wlog[i].a, ea[i]);
      chk("write_data", wlog[i].d, ed[i]);
    end
  endtask

  initial begin
    int d0, o0;
    reset = 1'b1;
    cyc(3);
    chk("reset_addr", addr, 16'h0000);
    chk("reset_busy", busy, 0);
    chk("reset_rw", rw, 0);
    reset = 1'b0;
    cyc(2);

    // Basic frame, then position wrap from 00 to FF.
    frame(8'h10);
    check_frame(8'h10, 4'h0, 8'h00);
    frame(8'h00);
    check_frame(8'h00, 4'h1, 8'h01);
    chk("wrap_col_addr", wlog[1].a, 16'hF2FF);
    chk("wrap_chr_addr", wlog[2].a, 16'hF0FF);

    // Frames 3..17: colour runs to 15 then wraps to 0 on frame 17, letter reaches 16.
    for (int f = 3; f <= 17; f++) begin
      frame(8'h40);
      check_frame(8'h40, 4'((f - 1) % 16), 8'(f - 1));
    end
    chk("frame17_colour", wlog[1].d, 8'h00);
    chk("frame17_letter", wlog[2].d, 8'h10);

    // vsync held high: one sequence only.
    d0 = done_cnt; o0 = ovr_cnt;
    wlog.delete();
    vsync = 1'b1;
    cyc(100);
    vsync = 1'b0;
    cyc(3);
    chk("held_done", done_cnt - d0, 1);
    chk("held_overrun", ovr_cnt - o0, 0);
    chk("held_writes", wlog.size(), 6);

    // Second rise while busy: one overrun, no extra sequence.
    d0 = done_cnt; o0 = ovr_cnt;
    wlog.delete();
    vsync = 1'b1;
    cyc(1);
    vsync = 1'b0;
    cyc(2);
    vsync = 1'b1;
    cyc(1);
    vsync = 1'b0;
    cyc(14);
    chk("ovr_done", done_cnt - d0, 1);
    chk("ovr_pulses", ovr_cnt - o0, 1);
    chk("ovr_writes", wlog.size(), 6);

    // Reset during WCOL of channel 1 aborts the sequence.
    din = 8'h10;
    wlog.delete();
    vsync = 1'b1;
    cyc(1);
    vsync = 1'b0;
    cyc(8);
    chk("abort_in_wcol", addr, 16'hF20F);
    reset = 1'b1;
    cyc(1);
    chk("abort_rw", rw, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr", addr, 16'h0000);
    reset = 1'b0;
    cyc(14);
    chk("abort_writes", wlog.size(), 5);
    frame(8'h10);
    check_frame(8'h10, 4'h0, 8'h00);

    cyc(2);
    chk("nch1_runs", runs1, 21);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
